// File: rtl/y_mul_seq_pkg.sv
// Types and defaults shared by the sequential multiplier and the CPU datapath.
package y_mul_seq_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/y_mul_seq_if.sv
// Request/result bundle between a multiply requester and y_mul_seq.
interface y_mul_seq_if import y_mul_seq_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b, sgn, done_ready,
    input  busy, done_valid, hi, lo
  );

  modport slave (
    input  start, a, b, sgn, done_ready,
    output busy, done_valid, hi, lo
  );

endinterface

// File: rtl/y_mul_seq_adder.sv
// WIDTH-bit ripple-carry adder used by the CPU datapath and the multiplier.
module yAdder import y_mul_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  output logic [WIDTH-1:0] z,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign z[gi]     = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[WIDTH];

endmodule

// File: rtl/y_mul_seq.sv
// Fixed-latency shift-add multiplier (mult/multu): magnitudes are multiplied
// over WIDTH cycles, then the product is negated in one extra cycle if needed.
module y_mul_seq import y_mul_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic    clk,
  input  logic    rst_n,
  y_mul_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             neg;
  logic             busy;
  logic             done_valid;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] run_next;
  logic [2*WIDTH-1:0] prod_neg;

  // -2^(WIDTH-1) negates to its own bit pattern, which read unsigned is the magnitude.
  assign mag_a = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign mag_b = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  // The multiplier lives in lo and is consumed from its LSB as the product shifts in.
  assign addend = lo[0] ? mcand : '0;

  yAdder #(.WIDTH(WIDTH)) u_add (
    .z    (sum),
    .cout (cout),
    .a    (hi),
    .b    (addend),
    .cin  (1'b0)
  );

  assign run_next = {cout, sum, lo[WIDTH-1:1]};
  assign prod_neg = ~{hi, lo} + (2*WIDTH)'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mcand      <= '0;
      hi         <= '0;
      lo         <= '0;
      neg        <= 1'b0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mcand <= mag_a;
            hi    <= '0;
            lo    <= mag_b;
            neg   <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          {hi, lo} <= run_next;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (neg) begin
            {hi, lo} <= prod_neg;
          end
          cnt        <= '0;
          busy       <= 1'b0;
          done_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          // A start arriving with done_ready is dropped; new work enters from IDLE only.
          if (bus.done_ready) begin
            done_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done_valid = done_valid;
  assign bus.hi         = hi;
  assign bus.lo         = lo;

endmodule
